// File: rtl/tx_iq_intf.sv
// Transmit I/Q interface: 32-entry sample FIFO between the wifi/loopback sources and the DAC,
// paced at one strobe per NUM_CLK_PER_SAMPLE clocks. Optional macro: TX_IQ_UNDERFLOW_CNT_EN.
module tx_iq_intf #(
    parameter int unsigned IQ_DATA_WIDTH      = 16,
    parameter int unsigned NUM_CLK_PER_SAMPLE = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       src_sel,
    input  logic [IQ_DATA_WIDTH-1:0]   wifi_tx_i,
    input  logic [IQ_DATA_WIDTH-1:0]   wifi_tx_q,
    input  logic                       wifi_tx_iq_valid,
    input  logic [2*IQ_DATA_WIDTH-1:0] s_axis_iq,
    input  logic                       s_axis_iq_valid,
    output logic                       iq_ready,
    input  logic                       tx_en,
    input  logic                       frame_end,
    input  logic [5:0]                 prefill_level,
    output logic [IQ_DATA_WIDTH-1:0]   dac_i,
    output logic [IQ_DATA_WIDTH-1:0]   dac_q,
    output logic                       dac_iq_valid,
    output logic                       busy,
    output logic                       underflow
`ifdef TX_IQ_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                underflow_cnt
`endif
);

    localparam int unsigned Depth = 32;
    localparam int unsigned PtrW  = 5;
    localparam int unsigned CntW  = 6;
    localparam int unsigned SampW = 2 * IQ_DATA_WIDTH;
    localparam int unsigned StrW  = $clog2(NUM_CLK_PER_SAMPLE);
    localparam logic [StrW-1:0] StrobeLast = StrW'(NUM_CLK_PER_SAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StPrefill, StStream, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [SampW-1:0]       mem_q [Depth];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [StrW-1:0]        str_cnt_q, str_cnt_d;
    logic                   fe_seen_q, fe_seen_d;
    logic [IQ_DATA_WIDTH-1:0] dac_i_q, dac_i_d, dac_q_q, dac_q_d;
    logic                   dac_valid_q, dac_valid_d;
    logic                   underflow_q, underflow_d;

    logic                   full, empty, sel_valid, wr_en, rd_en, strobe, streaming;
    logic [SampW-1:0]       sel_data, rd_data;
    logic [CntW-1:0]        eff_prefill;

    assign full      = (count_q == CntW'(Depth));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != StIdle);
    assign iq_ready  = tx_en && !full && busy;
    assign sel_valid = src_sel ? s_axis_iq_valid : wifi_tx_iq_valid;
    assign sel_data  = src_sel ? s_axis_iq : {wifi_tx_q, wifi_tx_i};
    assign wr_en     = sel_valid && iq_ready;
    // Counter is held at zero in IDLE, so strobe can only fire in the other states.
    assign strobe    = (str_cnt_q == StrobeLast);
    assign streaming = (state_q == StStream) || (state_q == StDrain);
    assign rd_en     = strobe && streaming && !empty;
    assign rd_data   = mem_q[rd_ptr_q];

    assign dac_i        = dac_i_q;
    assign dac_q        = dac_q_q;
    assign dac_iq_valid = dac_valid_q;
    assign underflow    = underflow_q;

    always_comb begin
        eff_prefill = prefill_level;
        if (prefill_level == '0) begin
            eff_prefill = CntW'(1);
        end else if (prefill_level > CntW'(Depth)) begin
            eff_prefill = CntW'(Depth);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (tx_en) state_d = StPrefill;
            StPrefill: if ((count_q >= eff_prefill) || fe_seen_q) state_d = StStream;
            StStream:  if (fe_seen_q) state_d = StDrain;
            StDrain:   if (strobe && empty) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (!tx_en) begin
            state_d = StIdle;
        end
    end

    // Any entry into IDLE flushes the FIFO and rewinds the pacing counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PtrW'(wr_en);
        rd_ptr_d  = rd_ptr_q + PtrW'(rd_en);
        count_d   = count_q + CntW'(wr_en) - CntW'(rd_en);
        str_cnt_d = strobe ? '0 : str_cnt_q + StrW'(1);
        fe_seen_d = fe_seen_q || (frame_end && (state_q != StIdle));
        if (state_d == StIdle) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            str_cnt_d = '0;
            fe_seen_d = 1'b0;
        end else if (state_q == StIdle) begin
            str_cnt_d = '0;
        end
    end

    always_comb begin
        dac_i_d     = dac_i_q;
        dac_q_d     = dac_q_q;
        dac_valid_d = 1'b0;
        underflow_d = 1'b0;
        if (state_d == StIdle) begin
            dac_i_d = '0;
            dac_q_d = '0;
        end else if (strobe && streaming) begin
            if (!empty) begin
                {dac_q_d, dac_i_d} = rd_data;
                dac_valid_d        = 1'b1;
            end else if (state_q == StStream) begin
                dac_i_d     = '0;
                dac_q_d     = '0;
                dac_valid_d = 1'b1;
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            str_cnt_q   <= '0;
            fe_seen_q   <= 1'b0;
            dac_i_q     <= '0;
            dac_q_q     <= '0;
            dac_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            str_cnt_q   <= str_cnt_d;
            fe_seen_q   <= fe_seen_d;
            dac_i_q     <= dac_i_d;
            dac_q_q     <= dac_q_d;
            dac_valid_q <= dac_valid_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sel_data;
        end
    end

`ifdef TX_IQ_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if ((state_q == StIdle) && (state_d == StPrefill)) begin
            uf_cnt_d = '0;
        end else if (underflow_d && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_tx_iq_intf.sv
// Randomized bench for tx_iq_intf against a queue-based frame model; directed scenarios first.
module tb_tx_iq_intf;

    localparam int W    = 16;
    localparam int NCLK = 5;
    localparam int ModeIdle    = 0;
    localparam int ModePrefill = 1;
    localparam int ModeStream  = 2;
    localparam int ModeDrain   = 3;

    logic           clk = 1'b0;
    logic           rstn;
    logic           src_sel;
    logic [W-1:0]   wifi_tx_i, wifi_tx_q;
    logic           wifi_tx_iq_valid;
    logic [2*W-1:0] s_axis_iq;
    logic           s_axis_iq_valid;
    logic           iq_ready;
    logic           tx_en;
    logic           frame_end;
    logic [5:0]     prefill_level;
    logic [W-1:0]   dac_i, dac_q;
    logic           dac_iq_valid;
    logic           busy;
    logic           underflow;
`ifdef TX_IQ_UNDERFLOW_CNT_EN
    logic [15:0]    underflow_cnt;
`endif

    tx_iq_intf #(
        .IQ_DATA_WIDTH      (W),
        .NUM_CLK_PER_SAMPLE (NCLK)
    ) u_dut (
        .clk              (clk),
        .rstn             (rstn),
        .src_sel          (src_sel),
        .wifi_tx_i        (wifi_tx_i),
        .wifi_tx_q        (wifi_tx_q),
        .wifi_tx_iq_valid (wifi_tx_iq_valid),
        .s_axis_iq        (s_axis_iq),
        .s_axis_iq_valid  (s_axis_iq_valid),
        .iq_ready         (iq_ready),
        .tx_en            (tx_en),
        .frame_end        (frame_end),
        .prefill_level    (prefill_level),
        .dac_i            (dac_i),
        .dac_q            (dac_q),
        .dac_iq_valid     (dac_iq_valid),
        .busy             (busy),
        .underflow        (underflow)
`ifdef TX_IQ_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt    (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame mode, queue of pending samples, clocks into the sample period.
    int             m_mode;
    int             m_phase;
    logic [2*W-1:0] m_fifo[$];
    bit             m_fe;
    logic [W-1:0]   m_di, m_dq;
    bit             m_dv, m_uf, m_wr;
    int             m_ufcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = ModeIdle;
        m_phase = 0;
        m_fifo.delete();
        m_fe    = 1'b0;
        m_di    = '0;
        m_dq    = '0;
        m_dv    = 1'b0;
        m_uf    = 1'b0;
        m_wr    = 1'b0;
        m_ufcnt = 0;
    endtask

    // One clock: check ready/busy before the edge, advance the model, check outputs after it.
    task automatic tick();
        bit             ready, wr, strobe;
        logic [2*W-1:0] data, head;
        int             size0, eff, nmode;
        #1;
        ready = tx_en && (m_fifo.size() < 32) && (m_mode != ModeIdle);
        check_eq("iq_ready", 32'(iq_ready), 32'(ready));
        check_eq("busy", 32'(busy), 32'(m_mode != ModeIdle));
        wr     = ready && (src_sel ? s_axis_iq_valid : wifi_tx_iq_valid);
        data   = src_sel ? s_axis_iq : {wifi_tx_q, wifi_tx_i};
        strobe = (m_mode != ModeIdle) && (m_phase == NCLK - 1);
        size0  = m_fifo.size();
        eff    = (int'(prefill_level) == 0) ? 1 : (int'(prefill_level) > 32) ? 32
               : int'(prefill_level);
        m_dv = 1'b0;
        m_uf = 1'b0;
        m_wr = wr;
        if (!tx_en) begin
            nmode = ModeIdle;
        end else begin
            case (m_mode)
                ModeIdle:    nmode = ModePrefill;
                ModePrefill: nmode = (size0 >= eff || m_fe) ? ModeStream : ModePrefill;
                ModeStream:  nmode = m_fe ? ModeDrain : ModeStream;
                default:     nmode = (strobe && size0 == 0) ? ModeIdle : ModeDrain;
            endcase
        end
        if (nmode == ModeIdle) begin
            m_fifo.delete();
            m_fe    = 1'b0;
            m_phase = 0;
            m_di    = '0;
            m_dq    = '0;
        end else begin
            if (m_mode == ModeIdle) m_ufcnt = 0;
            if (strobe && (m_mode == ModeStream || m_mode == ModeDrain)) begin
                if (size0 > 0) begin
                    head = m_fifo.pop_front();
                    m_di = head[W-1:0];
                    m_dq = head[2*W-1:W];
                    m_dv = 1'b1;
                end else if (m_mode == ModeStream) begin
                    m_di = '0;
                    m_dq = '0;
                    m_dv = 1'b1;
                    m_uf = 1'b1;
                    if (m_ufcnt < 65535) m_ufcnt++;
                end
            end
            if (wr) m_fifo.push_back(data);
            if (frame_end && m_mode != ModeIdle) m_fe = 1'b1;
            m_phase = (m_mode == ModeIdle || strobe) ? 0 : m_phase + 1;
        end
        m_mode = nmode;
        @(posedge clk);
        #1;
        check_eq("dac_i", 32'(dac_i), 32'(m_di));
        check_eq("dac_q", 32'(dac_q), 32'(m_dq));
        check_eq("dac_iq_valid", 32'(dac_iq_valid), 32'(m_dv));
        check_eq("underflow", 32'(underflow), 32'(m_uf));
`ifdef TX_IQ_UNDERFLOW_CNT_EN
        check_eq("underflow_cnt", 32'(underflow_cnt), 32'(m_ufcnt));
`endif
    endtask

    task automatic drive(input bit v);
        wifi_tx_i = W'($urandom);
        wifi_tx_q = W'($urandom);
        s_axis_iq = $urandom;
        if (src_sel) begin
            s_axis_iq_valid  = v;
            wifi_tx_iq_valid = 1'($urandom);
        end else begin
            wifi_tx_iq_valid = v;
            s_axis_iq_valid  = 1'($urandom);
        end
    endtask

    task automatic write_n(input int n, input int max_cyc);
        int acc = 0;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            drive(1'b1);
            tick();
            if (m_wr) acc++;
        end
        check_eq("accepted", 32'(acc), 32'(n));
        drive(1'b0);
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int c = 0; c < max_cyc && m_mode != ModeIdle; c++) tick();
        check_eq("reach_idle", 32'(busy), 32'd0);
    endtask

    task automatic stop_tx();
        tx_en = 1'b0;
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        src_sel = 1'b0;
        wifi_tx_i = '0;
        wifi_tx_q = '0;
        wifi_tx_iq_valid = 1'b0;
        s_axis_iq = '0;
        s_axis_iq_valid = 1'b0;
        tx_en = 1'b1;
        frame_end = 1'b0;
        prefill_level = 6'd8;
        model_reset();
        #12;
        check_eq("rst_iq_ready", 32'(iq_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dac_valid", 32'(dac_iq_valid), 32'd0);
        check_eq("rst_dac_i", 32'(dac_i), 32'd0);
        check_eq("rst_underflow", 32'(underflow), 32'd0);
        tx_en = 1'b0;
        #10;
        rstn = 1'b1;

        // Prefill and pacing
        prefill_level = 6'd8;
        src_sel = 1'b0;
        tx_en = 1'b1;
        write_n(20, 200);
        end_frame();
        wait_idle(400);
        stop_tx();

        // Underflow after two samples, no frame end
        prefill_level = 6'd2;
        tx_en = 1'b1;
        write_n(2, 20);
        repeat (45) tick();
        stop_tx();

        // Full / backpressure
        prefill_level = 6'd32;
        tx_en = 1'b1;
        write_n(40, 400);
        end_frame();
        wait_idle(600);
        stop_tx();

        // Loopback source with wifi garbage
        begin
            bit got = 1'b0;
            src_sel = 1'b1;
            prefill_level = 6'd1;
            tx_en = 1'b1;
            s_axis_iq = 32'h0002_0001;
            s_axis_iq_valid = 1'b1;
            wifi_tx_iq_valid = 1'b1;
            for (int c = 0; c < 10 && !got; c++) begin
                wifi_tx_i = W'($urandom);
                wifi_tx_q = W'($urandom);
                tick();
                got = m_wr;
            end
            s_axis_iq_valid = 1'b0;
            for (int c = 0; c < 60 && !dac_iq_valid; c++) tick();
            check_eq("lb_valid", 32'(dac_iq_valid), 32'd1);
            check_eq("lb_dac_i", 32'(dac_i), 32'd1);
            check_eq("lb_dac_q", 32'(dac_q), 32'd2);
            wifi_tx_iq_valid = 1'b0;
            end_frame();
            wait_idle(200);
            stop_tx();
        end

        // tx_en drop mid-stream
        src_sel = 1'b0;
        prefill_level = 6'd12;
        tx_en = 1'b1;
        write_n(12, 40);
        repeat (8) tick();
        stop_tx();
        check_eq("flush_count", 32'(u_dut.count_q), 32'd0);
        repeat (12) tick();

        // Clamp low and high with early frame end
        prefill_level = 6'd0;
        tx_en = 1'b1;
        write_n(1, 10);
        repeat (10) tick();
        end_frame();
        wait_idle(100);
        stop_tx();
        prefill_level = 6'd40;
        tx_en = 1'b1;
        write_n(5, 20);
        end_frame();
        wait_idle(200);
        stop_tx();

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            int n, dens;
            prefill_level = 6'($urandom_range(0, 40));
            src_sel = 1'($urandom_range(0, 1));
            tx_en = 1'b1;
            n = $urandom_range(1, 45);
            dens = $urandom_range(30, 100);
            for (int c = 0; c < n; c++) begin
                drive($urandom_range(1, 100) <= dens);
                frame_end = ($urandom_range(0, 30) == 0);
                tick();
            end
            frame_end = 1'b0;
            drive(1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 20)) tick();
                stop_tx();
            end else begin
                end_frame();
                wait_idle(2000);
                tx_en = 1'b0;
                frame_end = 1'($urandom_range(0, 1));
                tick();
                frame_end = 1'b0;
            end
        end

        // Reset mid-frame discards queued samples
        src_sel = 1'b0;
        prefill_level = 6'd4;
        tx_en = 1'b1;
        write_n(10, 40);
        repeat (7) tick();
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(dac_iq_valid), 32'd0);
        check_eq("mid_rst_dac_i", 32'(dac_i), 32'd0);
        check_eq("mid_rst_ready", 32'(iq_ready), 32'd0);
        model_reset();
        tx_en = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b1;
        prefill_level = 6'd1;
        tx_en = 1'b1;
        write_n(1, 10);
        end_frame();
        wait_idle(100);
        stop_tx();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
